// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle IF/ID/EX/MEM/WB control sequencer for the MIPS core.
// Instruction classes come from opcode masks, so the block also serves extended opcode sets.
// Data-memory accesses may stretch over MEM_WAIT extra cycles.
module multicycle_ctrl #(
  parameter int              OP_W       = 31,
  parameter logic [OP_W-1:0] LOAD_MASK  = 31'h01000000,
  parameter logic [OP_W-1:0] STORE_MASK = 31'h02000000,
  parameter logic [OP_W-1:0] BEQ_MASK   = 31'h04000000,
  parameter logic [OP_W-1:0] BNE_MASK   = 31'h08000000,
  parameter logic [OP_W-1:0] JUMP_MASK  = 31'h70000000,
  parameter logic [OP_W-1:0] LINK_MASK  = 31'h20000000,
  parameter int              MEM_WAIT   = 0,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             hold,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             dm_cs,
  output logic             dm_r,
  output logic             dm_w,
  output logic             br_taken,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  localparam logic [3:0]      WAIT_INIT = 4'(MEM_WAIT);
  localparam logic [OP_W-1:0] OP_ONE    = {{(OP_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic             load_q, load_d;
  logic             store_q, store_d;
  logic             beq_q, beq_d;
  logic             bne_q, bne_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic op_load, op_store, op_beq, op_bne, op_jump, op_link;
  logic op_none, op_multi, op_illegal;
  logic branch_hit;

  logic pc_we_c, ir_we_c, rf_we_c, dm_cs_c, dm_r_c, dm_w_c, br_taken_c;
  logic done_c, illegal_c;

  // Reduce the opcode against each class mask and flag empty or multi-hot opcodes.
  always_comb begin
    op_load    = |(op & LOAD_MASK);
    op_store   = |(op & STORE_MASK);
    op_beq     = |(op & BEQ_MASK);
    op_bne     = |(op & BNE_MASK);
    op_jump    = |(op & JUMP_MASK);
    op_link    = |(op & LINK_MASK);
    op_none    = (op == '0);
    op_multi   = |(op & (op - OP_ONE));
    op_illegal = op_none | op_multi;
  end

  // Sequencer: next state, wait counter, latched class flags and the raw strobes of the current phase.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    load_d     = load_q;
    store_d    = store_q;
    beq_d      = beq_q;
    bne_d      = bne_q;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    dm_cs_c    = 1'b0;
    dm_r_c     = 1'b0;
    dm_w_c     = 1'b0;
    br_taken_c = 1'b0;
    done_c     = 1'b0;
    illegal_c  = 1'b0;
    branch_hit = (beq_q & zero) | (bne_q & ~zero);

    case (state_q)
      ST_IF: begin
        if (!hold) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        if (op_illegal) begin
          illegal_c = 1'b1;
          done_c    = 1'b1;
          state_d   = ST_IF;
        end else if (op_jump) begin
          pc_we_c = 1'b1;
          rf_we_c = op_link;
          done_c  = 1'b1;
          state_d = ST_IF;
        end else begin
          load_d  = op_load;
          store_d = op_store;
          beq_d   = op_beq;
          bne_d   = op_bne;
          state_d = ST_EX;
        end
      end

      ST_EX: begin
        if (beq_q || bne_q) begin
          br_taken_c = branch_hit;
          pc_we_c    = branch_hit;
          done_c     = 1'b1;
          state_d    = ST_IF;
        end else if (load_q || store_q) begin
          wait_d  = WAIT_INIT;
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        // A load wins over a store if a custom mask set ever overlaps, keeping dm_r/dm_w exclusive.
        dm_cs_c = 1'b1;
        dm_r_c  = load_q;
        dm_w_c  = store_q & ~load_q;
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (load_q) begin
          state_d = ST_WB;
        end else begin
          done_c  = 1'b1;
          state_d = ST_IF;
        end
      end

      ST_WB: begin
        rf_we_c = 1'b1;
        done_c  = 1'b1;
        state_d = ST_IF;
      end

      default: begin
        state_d = ST_IF;
      end
    endcase
  end

  // Retired-instruction counter: every completion except an illegal opcode, wrapping naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (done_c && !illegal_c) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State, wait counter, class flags and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IF;
      wait_q  <= 4'd0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      beq_q   <= 1'b0;
      bne_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      load_q  <= load_d;
      store_q <= store_d;
      beq_q   <= beq_d;
      bne_q   <= bne_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while rst is high so a reset in mid-instruction never leaks a partial write.
  always_comb begin
    pc_we      = pc_we_c    & ~rst;
    ir_we      = ir_we_c    & ~rst;
    rf_we      = rf_we_c    & ~rst;
    dm_cs      = dm_cs_c    & ~rst;
    dm_r       = dm_r_c     & ~rst;
    dm_w       = dm_w_c     & ~rst;
    br_taken   = br_taken_c & ~rst;
    instr_done = done_c     & ~rst;
    illegal    = illegal_c  & ~rst;
    state      = state_q;
    instr_cnt  = cnt_q;
  end

  // Structural invariants of the strobe set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dm_r && dm_w));
      assert (!(rf_we && dm_w));
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized scoreboard bench for the multi-cycle control sequencer.
module tb_multicycle_ctrl;

  localparam int OP_W     = 31;
  localparam int MEM_WAIT = 2;
  localparam int CNT_W    = 32;

  localparam logic [30:0] LOAD_MASK  = 31'h01000000;
  localparam logic [30:0] STORE_MASK = 31'h02000000;
  localparam logic [30:0] BEQ_MASK   = 31'h04000000;
  localparam logic [30:0] BNE_MASK   = 31'h08000000;
  localparam logic [30:0] JUMP_MASK  = 31'h70000000;
  localparam logic [30:0] LINK_MASK  = 31'h20000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] op;
  logic        zero;
  logic        hold;
  logic        pc_we, ir_we, rf_we, dm_cs, dm_r, dm_w, br_taken;
  logic [2:0]  state;
  logic        instr_done, illegal;
  logic [31:0] instr_cnt;

  typedef struct {
    int          latency;
    int          pcCnt;
    int          irCnt;
    int          rfCnt;
    int          dmrCnt;
    int          dmwCnt;
    int          dmcsCnt;
    int          brCnt;
    int          illCnt;
    int          lastState;
    logic [31:0] cntBefore;
  } exp_t;

  exp_t        expQ[$];
  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [31:0] modelCnt = 32'd0;
  bit          monOn = 1'b0;

  int cyc, aPc, aIr, aRf, aDmr, aDmw, aDmcs, aBr, aIll;
  bit active = 1'b0;

  multicycle_ctrl #(
    .OP_W(OP_W), .LOAD_MASK(LOAD_MASK), .STORE_MASK(STORE_MASK), .BEQ_MASK(BEQ_MASK),
    .BNE_MASK(BNE_MASK), .JUMP_MASK(JUMP_MASK), .LINK_MASK(LINK_MASK),
    .MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .hold(hold),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w),
    .br_taken(br_taken), .state(state), .instr_done(instr_done), .illegal(illegal),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, reports and counts a miscompare when actual differs from required.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Reference model: whole-instruction response derived from the instruction class rules.
  function automatic exp_t predict(input logic [30:0] o, input logic z);
    exp_t e;
    bit   taken;
    e = '{default: 0};
    e.irCnt = 1;
    e.pcCnt = 1;
    if ($countones(o) != 1) begin
      e.latency = 2; e.illCnt = 1; e.lastState = 1;
    end else if ((o & JUMP_MASK) != 0) begin
      e.latency = 2; e.pcCnt = 2; e.lastState = 1;
      e.rfCnt = ((o & LINK_MASK) != 0) ? 1 : 0;
    end else if ((o & (BEQ_MASK | BNE_MASK)) != 0) begin
      taken = ((o & BEQ_MASK) != 0) ? z : !z;
      e.latency = 3; e.lastState = 2;
      e.pcCnt = 1 + int'(taken);
      e.brCnt = int'(taken);
    end else if ((o & LOAD_MASK) != 0) begin
      e.latency = 5 + MEM_WAIT; e.lastState = 4;
      e.dmrCnt = 1 + MEM_WAIT; e.dmcsCnt = 1 + MEM_WAIT; e.rfCnt = 1;
    end else if ((o & STORE_MASK) != 0) begin
      e.latency = 4 + MEM_WAIT; e.lastState = 3;
      e.dmwCnt = 1 + MEM_WAIT; e.dmcsCnt = 1 + MEM_WAIT;
    end else begin
      e.latency = 4; e.lastState = 4; e.rfCnt = 1;
    end
    return e;
  endfunction

  // Issue one instruction (called just after a rising edge with the sequencer in IF) and wait for it to retire.
  task automatic applyStimulus(input logic [30:0] o, input logic z, input int h);
    exp_t e;
    bit   seen;
    e = predict(o, z);
    e.cntBefore = modelCnt;
    if (e.illCnt == 0) modelCnt = modelCnt + 32'd1;
    expQ.push_back(e);
    op   = o;
    zero = z;
    hold = (h > 0);
    repeat (h) @(posedge clk);
    #1;
    hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (instr_done) seen = 1'b1;
    end
    if (!seen) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL instr_done_timeout: got no instr_done in 40 cycles, required one (op=%h)", o);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: accumulates strobes per instruction and checks against the scoreboard at each completion.
  always @(negedge clk) begin
    if (rst || !monOn) begin
      active = 1'b0;
    end else begin
      checkOutput("dm_r_and_dm_w", {63'd0, dm_r & dm_w}, 64'd0);
      checkOutput("rf_we_and_dm_w", {63'd0, rf_we & dm_w}, 64'd0);
      if (hold && state == 3'd0) checkOutput("ir_we_under_hold", {63'd0, ir_we}, 64'd0);
      if (ir_we) begin
        active = 1'b1;
        cyc = 0; aPc = 0; aIr = 0; aRf = 0; aDmr = 0; aDmw = 0; aDmcs = 0; aBr = 0; aIll = 0;
      end
      if (active) begin
        cyc++;
        aPc += int'(pc_we); aIr += int'(ir_we); aRf += int'(rf_we);
        aDmr += int'(dm_r); aDmw += int'(dm_w); aDmcs += int'(dm_cs);
        aBr += int'(br_taken); aIll += int'(illegal);
        if (instr_done) begin
          if (expQ.size() == 0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL scoreboard_empty: got instr_done, required no completion pending");
          end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("latency",    64'(cyc),   64'(e.latency));
            checkOutput("pc_we_cnt",  64'(aPc),   64'(e.pcCnt));
            checkOutput("ir_we_cnt",  64'(aIr),   64'(e.irCnt));
            checkOutput("rf_we_cnt",  64'(aRf),   64'(e.rfCnt));
            checkOutput("dm_r_cnt",   64'(aDmr),  64'(e.dmrCnt));
            checkOutput("dm_w_cnt",   64'(aDmw),  64'(e.dmwCnt));
            checkOutput("dm_cs_cnt",  64'(aDmcs), 64'(e.dmcsCnt));
            checkOutput("br_taken_cnt", 64'(aBr), 64'(e.brCnt));
            checkOutput("illegal_cnt", 64'(aIll), 64'(e.illCnt));
            checkOutput("final_state", {61'd0, state}, 64'(e.lastState));
            checkOutput("instr_cnt",  {32'd0, instr_cnt}, {32'd0, e.cntBefore});
          end
          active = 1'b0;
        end
      end else if (instr_done) begin
        checkOutput("stray_instr_done", {63'd0, instr_done}, 64'd0);
      end
    end
  end

  // Directed cases, randomized traffic, then a reset in the middle of a load's memory phase.
  initial begin
    logic [30:0] o;
    int          cat, b1, b2;
    bit          found;

    rst = 1'b1; op = '0; zero = 1'b0; hold = 1'b0;
    #12;
    checkOutput("reset_state",     {61'd0, state}, 64'd0);
    checkOutput("reset_ir_we",     {63'd0, ir_we}, 64'd0);
    checkOutput("reset_pc_we",     {63'd0, pc_we}, 64'd0);
    checkOutput("reset_instr_cnt", {32'd0, instr_cnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    monOn = 1'b1;

    applyStimulus(31'h00000001, 1'b0, 0);
    applyStimulus(31'h00000001 << 24, 1'b0, 0);
    applyStimulus(31'h00000001 << 25, 1'b0, 0);
    applyStimulus(31'h00000001 << 26, 1'b1, 0);
    applyStimulus(31'h00000001 << 26, 1'b0, 0);
    applyStimulus(31'h00000001 << 27, 1'b0, 0);
    applyStimulus(31'h00000001 << 27, 1'b1, 0);
    applyStimulus(31'h00000001 << 28, 1'b0, 0);
    applyStimulus(31'h00000001 << 29, 1'b0, 0);
    applyStimulus(31'h00000001 << 30, 1'b0, 0);
    applyStimulus(31'h00000000, 1'b0, 0);
    applyStimulus(31'h00000003, 1'b0, 0);
    applyStimulus(31'h00000001, 1'b0, 5);

    for (int n = 0; n < 150; n++) begin
      cat = $urandom_range(0, 9);
      case (cat)
        3: o = 31'h00000001 << 24;
        4: o = 31'h00000001 << 25;
        5: o = 31'h00000001 << 26;
        6: o = 31'h00000001 << 27;
        7: o = 31'h00000001 << $urandom_range(28, 30);
        8: begin
          if ($urandom_range(0, 2) == 0) begin
            o = '0;
          end else begin
            b1 = $urandom_range(0, 30);
            b2 = (b1 + $urandom_range(1, 30)) % 31;
            o = (31'h00000001 << b1) | (31'h00000001 << b2);
          end
        end
        default: o = 31'h00000001 << $urandom_range(0, 23);
      endcase
      applyStimulus(o, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end

    checkOutput("cnt_before_reset", {32'd0, instr_cnt}, {32'd0, modelCnt});

    monOn = 1'b0;
    op = 31'h00000001 << 24; zero = 1'b0; hold = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd3) found = 1'b1;
    end
    checkOutput("reached_mem", {63'd0, found}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_state",      {61'd0, state}, 64'd0);
    checkOutput("rst_mid_dm_cs",      {63'd0, dm_cs}, 64'd0);
    checkOutput("rst_mid_dm_r",       {63'd0, dm_r}, 64'd0);
    checkOutput("rst_mid_rf_we",      {63'd0, rf_we}, 64'd0);
    checkOutput("rst_mid_ir_we",      {63'd0, ir_we}, 64'd0);
    checkOutput("rst_mid_pc_we",      {63'd0, pc_we}, 64'd0);
    checkOutput("rst_mid_instr_done", {63'd0, instr_done}, 64'd0);
    checkOutput("rst_mid_instr_cnt",  {32'd0, instr_cnt}, 64'd0);
    modelCnt = 32'd0;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    monOn = 1'b1;
    applyStimulus(31'h00000001, 1'b0, 0);
    applyStimulus(31'h00000001 << 24, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_instr_cnt", {32'd0, instr_cnt}, {32'd0, modelCnt});
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
